// File: rtl/pad_stream_gen.sv
// Streams a frame from memory with a one-pixel zero border and tracks which
// downstream edge results (LAT cycles later) belong to interior pixels.
module pad_stream_gen #(
  parameter int unsigned IMG_W = 480,
  parameter int unsigned IMG_H = 360,
  parameter int unsigned LAT   = 482
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        mem_rd_en,
  output logic [17:0] mem_addr,
  input  logic [23:0] mem_rdata,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        edge_valid,
  output logic [8:0]  out_x,
  output logic [8:0]  out_y,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PW   = IMG_W + 2;
  localparam int unsigned PH   = IMG_H + 2;
  localparam int unsigned NPAD = PW * PH;
  localparam int unsigned NTOT = NPAD + LAT;
  localparam int unsigned SW   = $clog2(NTOT + 1);
  localparam int unsigned PMAX = (PW > PH) ? PW : PH;
  localparam int unsigned PosW = $clog2(PMAX + 2);

  localparam logic [SW-1:0]   NpadS   = SW'(NPAD);
  localparam logic [SW-1:0]   NpadM1S = SW'(NPAD - 1);
  localparam logic [SW-1:0]   NtotS   = SW'(NTOT);
  localparam logic [SW-1:0]   LatS    = SW'(LAT);
  localparam logic [PosW-1:0] PwM1    = PosW'(PW - 1);
  localparam logic [PosW-1:0] ImgWP   = PosW'(IMG_W);
  localparam logic [PosW-1:0] ImgHP   = PosW'(IMG_H);

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

  state_e          state_q;
  logic [SW-1:0]   s_q;
  logic [PosW-1:0] rd_r_q, rd_c_q;   // padded position of index s+1
  logic [PosW-1:0] ev_r_q, ev_c_q;   // padded position of the next edge index to emit
  logic [17:0]     raddr_q;
  logic            pix_en_q;

  logic [SW-1:0]   n_nxt;
  logic [PosW-1:0] rd_r_nxt, rd_c_nxt, ev_r_nxt, ev_c_nxt;
  logic            rd_go, pix_go, ev_go, ev_in;

  function automatic logic interior(input logic [PosW-1:0] r, input logic [PosW-1:0] c);
    return (r != '0) && (r <= ImgHP) && (c != '0) && (c <= ImgWP);
  endfunction

  always_comb begin
    n_nxt    = s_q + SW'(1);
    rd_c_nxt = (rd_c_q == PwM1) ? '0 : rd_c_q + PosW'(1);
    rd_r_nxt = (rd_c_q == PwM1) ? rd_r_q + PosW'(1) : rd_r_q;
    ev_c_nxt = (ev_c_q == PwM1) ? '0 : ev_c_q + PosW'(1);
    ev_r_nxt = (ev_c_q == PwM1) ? ev_r_q + PosW'(1) : ev_r_q;
    pix_go   = (n_nxt < NpadS) && interior(rd_r_q, rd_c_q);
    rd_go    = (n_nxt < NpadM1S) && interior(rd_r_nxt, rd_c_nxt);
    ev_go    = (n_nxt >= LatS);
    ev_in    = interior(ev_r_q, ev_c_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      s_q        <= '0;
      rd_r_q     <= '0;
      rd_c_q     <= '0;
      ev_r_q     <= '0;
      ev_c_q     <= '0;
      raddr_q    <= '0;
      pix_en_q   <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      edge_valid <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            // Index 0 and 1 lie on the top border: no pixel and no read yet.
            state_q <= StStream;
            busy    <= 1'b1;
            s_q     <= '0;
            rd_r_q  <= '0;
            rd_c_q  <= PosW'(1);
            raddr_q <= '0;
            ev_r_q  <= '0;
            ev_c_q  <= (LAT == 0) ? PosW'(1) : '0;
          end
        end
        StStream, StFlush: begin
          s_q       <= n_nxt;
          rd_r_q    <= rd_r_nxt;
          rd_c_q    <= rd_c_nxt;
          pix_en_q  <= pix_go;
          mem_rd_en <= rd_go;
          if (rd_go) begin
            mem_addr <= raddr_q;
            raddr_q  <= raddr_q + 18'd1;
          end
          if (ev_go) begin
            edge_valid <= ev_in;
            out_x      <= ev_in ? 9'(ev_c_q - PosW'(1)) : '0;
            out_y      <= ev_in ? 9'(ev_r_q - PosW'(1)) : '0;
            ev_r_q     <= ev_r_nxt;
            ev_c_q     <= ev_c_nxt;
          end else begin
            edge_valid <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
          end
          if (n_nxt == NtotS) begin
            state_q    <= StDone;
            busy       <= 1'b0;
            done       <= 1'b1;
            pix_en_q   <= 1'b0;
            mem_rd_en  <= 1'b0;
            edge_valid <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
          end else if (n_nxt >= NpadS) begin
            state_q <= StFlush;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // mem_rdata is the memory's registered output for the read issued last cycle,
  // so only the border gating sits in front of the operator.
  assign R = pix_en_q ? mem_rdata[23:16] : '0;
  assign G = pix_en_q ? mem_rdata[15:8]  : '0;
  assign B = pix_en_q ? mem_rdata[7:0]   : '0;

endmodule

// File: tb/tb_pad_stream_gen.sv
// Self-checking bench for pad_stream_gen on a 4x3 image with LAT=6, using a
// division-based reference of the padded raster and a random frame memory.
module tb_pad_stream_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int L    = 6;
  localparam int PW   = W + 2;
  localparam int PH   = H + 2;
  localparam int NPAD = PW * PH;
  localparam int NTOT = NPAD + L;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_rd_en;
  logic [17:0] mem_addr;
  logic [23:0] mem_rdata;
  logic [7:0]  R, G, B;
  logic        edge_valid;
  logic [8:0]  out_x, out_y;
  logic        busy, done;

  logic [23:0] mem [W*H];
  int passed = 0;
  int total  = 0;
  int ev_count;

  pad_stream_gen #(.IMG_W(W), .IMG_H(H), .LAT(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .R         (R),
    .G         (G),
    .B         (B),
    .edge_valid(edge_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; garbage whenever no read was issued.
  always @(posedge clk) begin
    int ma;
    ma = int'(mem_addr);
    if (mem_rd_en === 1'b1 && ma < W * H) mem_rdata <= mem[ma];
    else mem_rdata <= 24'($urandom);
  end

  function automatic bit interior(int idx);
    int r, c;
    if (idx < 0) return 1'b0;
    r = idx / PW;
    c = idx % PW;
    return (r >= 1) && (r <= H) && (c >= 1) && (c <= W);
  endfunction

  function automatic int pix_addr(int idx);
    return (idx / PW - 1) * W + (idx % PW - 1);
  endfunction

  task automatic check(input string tag, input int n, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, n, obs, exp);
  endtask

  task automatic check_idle(input int n);
    check("idle_busy", n, busy, 0);
    check("idle_done", n, done, 0);
    check("idle_rd_en", n, mem_rd_en, 0);
    check("idle_rgb", n, {R, G, B}, 0);
    check("idle_edge_valid", n, edge_valid, 0);
    check("idle_xy", n, {out_x, out_y}, 0);
  endtask

  task automatic check_reset(input int n);
    check_idle(n);
    check("reset_addr", n, mem_addr, 0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < W * H; i++) mem[i] = 24'($urandom);
  endtask

  task automatic run_frame(input int rst_at, input bit extra);
    int k;
    bit exp_rd, exp_ev;
    logic [23:0] exp_rgb;
    int extra_at;
    extra_at = $urandom_range(0, NTOT - 1);
    ev_count = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n <= NTOT; n++) begin
      @(negedge clk);
      exp_rd = (n + 1 < NPAD) && interior(n + 1);
      check("busy", n, busy, n < NTOT);
      check("done", n, done, n == NTOT);
      check("rd_en", n, mem_rd_en, exp_rd);
      if (exp_rd) check("addr", n, mem_addr, pix_addr(n + 1));
      exp_rgb = (n < NPAD && interior(n)) ? mem[pix_addr(n)] : 24'd0;
      check("rgb", n, {R, G, B}, exp_rgb);
      k = n - L;
      exp_ev = interior(k);
      check("edge_valid", n, edge_valid, exp_ev);
      check("out_x", n, out_x, exp_ev ? k % PW - 1 : 0);
      check("out_y", n, out_y, exp_ev ? k / PW - 1 : 0);
      if (edge_valid === 1'b1) ev_count++;
      if (n == rst_at) begin
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_reset(n + 1);
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_idle(n + 2 + i);
        end
        return;
      end
      start = extra && (n == 10 || n == NTOT || n == extra_at);
    end
    @(negedge clk);
    start = 1'b0;
    check_idle(NTOT + 1);
    check("edge_count", NTOT + 1, ev_count, W * H);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset(-1);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle(-1);

    fill_mem();
    run_frame(-1, 1'b0);
    fill_mem();
    run_frame(-1, 1'b1);
    run_frame(15, 1'b0);
    run_frame(-1, 1'b0);
    fill_mem();
    run_frame($urandom_range(1, NTOT - 1), 1'b1);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    fill_mem();
    run_frame(-1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
